vedic_prod_accum: RTL and testbench

//   Sequential accumulator directly downstream of the 32x32 Vedic multiplier.

---
 rtl/vedic_prod_accum_if.sv | 28 ++
 rtl/vedic_prod_accum.sv | 111 +++++++++++
 tb/tb_vedic_prod_accum.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_prod_accum_if.sv
// Handshake bundle between the product source, the accumulator and the sum consumer.
// master = job/product source and result consumer, slave = the accumulator.
interface vedic_prod_accum_if #(
  parameter int PROD_W = 64,
  parameter int GUARD  = 8,
  parameter int CNT_W  = 8
);
  logic                      start;
  logic [CNT_W-1:0]          len;
  logic                      prod_valid;
  logic [PROD_W-1:0]         prod;
  logic                      prod_ready;
  logic                      acc_valid;
  logic [PROD_W+GUARD-1:0]   acc_out;
  logic                      acc_ready;
  logic                      busy;
  logic                      overflow;

  modport master (
    output start, len, prod_valid, prod, acc_ready,
    input  prod_ready, acc_valid, acc_out, busy, overflow
  );

  modport slave (
    input  start, len, prod_valid, prod, acc_ready,
    output prod_ready, acc_valid, acc_out, busy, overflow
  );
endinterface

// File: rtl/vedic_prod_accum.sv
// Sums a programmed number of unsigned multiplier products into a guarded
// accumulator and holds the result until the consumer takes it.
module vedic_prod_accum #(
  parameter int PROD_W = 64,
  parameter int GUARD  = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  vedic_prod_accum_if.slave  bus
);
  localparam int ACC_W = PROD_W + GUARD;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               prod_ready_q, prod_ready_d;
  logic               acc_valid_q, acc_valid_d;
  logic               busy_q, busy_d;
  logic [ACC_W:0]     sum;

  // Wrapping add; the extra MSB is the carry out of the accumulator.
  function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
    logic [ACC_W-1:0] p_ext;
    p_ext = ACC_W'(p);
    return {1'b0, a} + {1'b0, p_ext};
  endfunction

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    prod_ready_d = prod_ready_q;
    acc_valid_d  = acc_valid_q;
    busy_d       = busy_q;
    sum          = add_carry(acc_q, bus.prod);
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d  = '0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          if (bus.len != '0) begin
            state_d      = ACC;
            cnt_d        = bus.len;
            prod_ready_d = 1'b1;
          end else begin
            state_d     = DONE;
            acc_valid_d = 1'b1;
          end
        end
      end
      ACC: begin
        if (bus.prod_valid && prod_ready_q) begin
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d      = DONE;
            prod_ready_d = 1'b0;
            acc_valid_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.acc_ready) begin
          state_d     = IDLE;
          acc_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        prod_ready_d = 1'b0;
        acc_valid_d  = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      acc_valid_q  <= acc_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.prod_ready = prod_ready_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.acc_out    = acc_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_vedic_prod_accum.sv
// Scoreboard bench: a GUARD=8 and a GUARD=0 accumulator run the same jobs in lockstep.
module tb_vedic_prod_accum;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        prod_valid = 1'b0;
  logic [63:0] prod = '0;
  logic        acc_ready = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  vedic_prod_accum_if #(.PROD_W(64), .GUARD(8), .CNT_W(8)) if8 ();
  vedic_prod_accum_if #(.PROD_W(64), .GUARD(0), .CNT_W(8)) if0 ();

  assign if8.start = start;      assign if0.start = start;
  assign if8.len = len;          assign if0.len = len;
  assign if8.prod_valid = prod_valid; assign if0.prod_valid = prod_valid;
  assign if8.prod = prod;        assign if0.prod = prod;
  assign if8.acc_ready = acc_ready;   assign if0.acc_ready = acc_ready;

  vedic_prod_accum #(.PROD_W(64), .GUARD(8), .CNT_W(8)) u_g8 (.clk(clk), .rst(rst), .bus(if8.slave));
  vedic_prod_accum #(.PROD_W(64), .GUARD(0), .CNT_W(8)) u_g0 (.clk(clk), .rst(rst), .bus(if0.slave));

  typedef struct {
    logic [71:0] a8;
    logic        o8;
    logic [63:0] a0;
    logic        o0;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected result per completed result handshake.
  always @(negedge clk) begin
    if (!rst && if8.acc_valid && acc_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_result: got %0h expected none", if8.acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc_out_g8", 128'(if8.acc_out), 128'(e.a8));
        chk("overflow_g8", 128'(if8.overflow), 128'(e.o8));
        chk("valid_g0", 128'(if0.acc_valid), 128'(1'b1));
        chk("acc_out_g0", 128'(if0.acc_out), 128'(e.a0));
        chk("overflow_g0", 128'(if0.overflow), 128'(e.o0));
      end
    end
  end

  task automatic push_exp(input logic [71:0] a8, input logic o8, input logic [63:0] a0, input logic o0);
    exp_t e;
    e.a8 = a8; e.o8 = o8; e.a0 = a0; e.o0 = o0;
    sb.push_back(e);
  endtask

  task automatic start_job(input int n);
    @(posedge clk) #1;
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic send_prod(input logic [63:0] p, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(posedge clk) #1;
    prod_valid = 1'b1;
    prod       = p;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (if8.prod_ready) begin
        @(posedge clk) #1;
        ok = 1'b1;
        break;
      end
    end
    prod_valid = 1'b0;
    if (!ok) chk("prod_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic take_result(input int hold);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (if8.acc_valid) begin ok = 1'b1; break; end
      @(posedge clk) #1;
    end
    if (!ok) chk("acc_valid_timeout", 128'(0), 128'(1));
    repeat (hold) @(posedge clk) #1;
    acc_ready = 1'b1;
    @(posedge clk) #1;
    acc_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc_valid", 128'(if8.acc_valid), 128'(0));
    chk("rst_prod_ready", 128'(if8.prod_ready), 128'(0));
    chk("rst_busy", 128'(if8.busy), 128'(0));
    chk("rst_acc_out", 128'(if8.acc_out), 128'(0));
    chk("rst_overflow", 128'(if8.overflow), 128'(0));

    // Test 1: 6+7+8 on consecutive cycles.
    push_exp(72'd21, 1'b0, 64'd21, 1'b0);
    start_job(3);
    chk("t1_busy", 128'(if8.busy), 128'(1));
    send_prod(64'd6, 0);
    send_prod(64'd7, 0);
    chk("t1_valid_early", 128'(if8.acc_valid), 128'(0));
    send_prod(64'd8, 0);
    chk("t1_valid_after_last", 128'(if8.acc_valid), 128'(1));
    take_result(0);

    // Test 2: (2^32-1)^2 four times with one-cycle valid gaps.
    push_exp(72'h3_FFFF_FFF8_0000_0004, 1'b0, 64'hFFFF_FFF8_0000_0004, 1'b1);
    start_job(4);
    for (int i = 0; i < 4; i++) send_prod(64'hFFFF_FFFE_0000_0001, 1);
    chk("t2_no_extra_ready", 128'(if8.prod_ready), 128'(0));
    take_result(0);

    // Test 3: len=0 goes straight to DONE and holds there.
    push_exp(72'd0, 1'b0, 64'd0, 1'b0);
    start_job(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_valid_held", 128'(if8.acc_valid), 128'(1));
    end
    @(posedge clk) #1;
    take_result(0);
    @(negedge clk);
    chk("t3_released", 128'(if8.acc_valid), 128'(0));

    // Test 4: 2^63 + 2^63 wraps only the unguarded instance.
    push_exp(72'h1_0000_0000_0000_0000, 1'b0, 64'd0, 1'b1);
    start_job(2);
    send_prod(64'h8000_0000_0000_0000, 0);
    send_prod(64'h8000_0000_0000_0000, 0);
    take_result(2);
    @(negedge clk);
    chk("t4_ovf_sticky_idle", 128'(if0.overflow), 128'(1));

    // Test 5: reset mid-job, then ignored start pulses, then 9.
    start_job(5);
    send_prod(64'd100, 0);
    send_prod(64'd200, 0);
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 128'(if8.busy), 128'(0));
    chk("t5_rst_prod_ready", 128'(if8.prod_ready), 128'(0));
    chk("t5_rst_acc_out", 128'(if8.acc_out), 128'(0));
    chk("t5_rst_valid", 128'(if8.acc_valid), 128'(0));
    push_exp(72'd9, 1'b0, 64'd9, 1'b0);
    start_job(1);
    chk("t5_ovf_cleared", 128'(if0.overflow), 128'(0));
    start = 1'b1; len = 8'd7;
    @(posedge clk) #1;
    start = 1'b0;
    send_prod(64'd9, 0);
    start = 1'b1; len = 8'd3;
    @(posedge clk) #1;
    start = 1'b0;
    take_result(1);
    repeat (2) @(negedge clk);
    chk("t5_idle_after", 128'(if8.busy), 128'(0));

    // Test 6: random products a*b, random gaps and hold-offs.
    for (int j = 0; j < 40; j++) begin
      int n;
      logic [72:0] s8;
      logic [64:0] s0;
      logic o8, o0;
      logic [63:0] ps[$];
      n  = $urandom_range(1, 20);
      s8 = '0; s0 = '0; o8 = 1'b0; o0 = 1'b0;
      ps.delete();
      for (int k = 0; k < n; k++) begin
        logic [31:0] a, b;
        logic [63:0] p;
        a = $urandom();
        b = $urandom();
        if (k % 7 == 3) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        p = 64'(a) * 64'(b);
        ps.push_back(p);
        s8 = {1'b0, s8[71:0]} + 73'(p);
        if (s8[72]) o8 = 1'b1;
        s0 = {1'b0, s0[63:0]} + 65'(p);
        if (s0[64]) o0 = 1'b1;
      end
      push_exp(s8[71:0], o8, s0[63:0], o0);
      start_job(n);
      for (int k = 0; k < n; k++) send_prod(ps[k], $urandom_range(0, 2));
      take_result($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
